turn_scheduler: RTL
===================

Name: turn_scheduler

Overview:
- Sequencing controller that sits between the nine cell buttons and the board datapath (cell registers plus win detectors).
- Accepts one move at a time and resolves simultaneous presses by fixed priority.
- Rejects presses on occupied cells, issues a single write strobe to the board, and waits for the win detectors to settle.
- Alternates turns and latches the game result until a new game is requested.

Parameters:
- SETTLE_CYCLES, 2: cycles to wait after a write strobe before sampling p1_win/p2_win. Legal range 1..7.
- FIRST_PLAYER, 0: player who moves first after reset or new game. 0 = P1, 1 = P2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- btn  in  9  cell buttons, already synchronized and debounced. Bit 0 = cell a … bit 8 = cell i. Level-sensitive.
- new_game  in  1  synchronous request to abort or finish the game and clear the board.
- cell_occ  in  9  per-cell occupied flags from the board.
- p1_win  in  1  P1 three-in-a-row flag from the board.
- p2_win  in  1  P2 three-in-a-row flag from the board.
- write_en  out  1  one-cycle board write strobe.
- write_sel  out  9  one-hot cell being written. Valid only while write_en=1, else 0.
- write_player  out  1  owner of the written cell. 0 = P1, 1 = P2.
- clear_board  out  1  one-cycle board clear strobe.
- turn  out  1  player to move. 0 = P1, 1 = P2.
- game_over  out  1  game finished. Held until new_game.
- winner  out  2  00 = none, 01 = P1, 10 = P2. Valid while game_over=1.
- draw  out  1  board full with no winner.
- move_count  out  4  committed moves, 0..9.
- illegal  out  1  one-cycle pulse when a press targets an occupied cell.

Behaviour:
- Reset (asynchronous, active-high):
  - state = RELEASE
  - turn = FIRST_PLAYER
  - move_count = 0, winner = 00
  - all other outputs 0
- States: RELEASE, READY, COMMIT, SETTLE, EVAL, OVER. Encoding is defined in the package.
- RELEASE: wait for btn == 0, then go to READY next cycle. A button held through reset or from the previous move is never accepted.
- READY: if btn != 0, pick the lowest set index.
  - Cell occupied: pulse illegal for 1 cycle, go to RELEASE. turn and move_count unchanged.
  - Cell free: latch the one-hot selection, go to COMMIT.
- COMMIT, exactly 1 cycle:
  - Drive write_en=1, write_sel=latched, write_player=turn.
  - move_count increments on this cycle.
  - Load the settle counter, go to SETTLE.
- Latency: press seen in READY at cycle N gives write_en at N+1.
- SETTLE: count SETTLE_CYCLES cycles, then go to EVAL. Buttons are ignored.
- EVAL, 1 cycle, rules in priority order:
  - Win flag set for the mover: winner = mover.
  - Otherwise, win flag set for the other player (fault case): winner = that player.
  - If both flags are set: winner = mover.
  - Any winner: game_over=1, go to OVER.
  - Otherwise, move_count == 9: draw=1, game_over=1, go to OVER.
  - Otherwise: toggle turn, go to RELEASE.
- OVER: all buttons ignored. Outputs hold.
- new_game (any state, highest priority):
  - Next cycle: clear_board=1 for 1 cycle.
  - move_count=0, winner=00, draw=0, game_over=0, turn=FIRST_PLAYER.
  - Go to RELEASE.
  - A new_game arriving in COMMIT's cycle suppresses that write.
  - new_game and btn in the same cycle: new_game wins.
- move_count saturates at 9. It never wraps.
- write_en and clear_board are never high in the same cycle.
- write_en is never issued for a cell whose cell_occ was 1 when sampled.

Decomposition:
- Package tictactoe_pkg contains:
  - NUM_CELLS = 9
  - player constants P1 = 0, P2 = 1
  - winner codes
  - state enum for turn_scheduler
- Sub-module cell_priority_pick, combinational: 9-bit request in; lowest-index one-hot out plus an any-request flag. Instantiated once in READY's selection path.

Test Plan:
- Reset held while btn=9'h010 → after reset release, no write_en until btn=0. Then btn=9'h004 → write_en=1, write_sel=9'h004, write_player=0 one cycle later; turn=1 after EVAL.
- btn=9'h011 in READY, both cells free → write_sel=9'h001 only; move_count 0→1.
- cell_occ=9'h001, btn=9'h001 → illegal pulses 1 cycle, no write_en, turn unchanged, move_count unchanged.
- Sequence a,d,b,e,c (P1 on 0,1,2) with p1_win asserted after the 5th write → game_over=1, winner=01, move_count=5. Further presses give no write_en.
- Nine legal moves with p1_win = p2_win = 0 → draw=1, game_over=1, winner=00, move_count=9.
- new_game pulsed in SETTLE mid-game → clear_board 1 cycle, move_count=0, turn=FIRST_PLAYER, state RELEASE. new_game together with btn → no write_en.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// Shared constants, winner codes and scheduler state encoding for the tic-tac-toe board slice.
package tictactoe_pkg;

  localparam int NUM_CELLS = 9;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  typedef enum logic [2:0] {
    ST_RELEASE = 3'd0,
    ST_READY   = 3'd1,
    ST_COMMIT  = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_EVAL    = 3'd4,
    ST_OVER    = 3'd5
  } sched_state_e;

  function automatic logic [1:0] winner_code(input logic player);
    return (player == P2) ? WIN_P2 : WIN_P1;
  endfunction

endpackage

// File: rtl/turn_scheduler_pick.sv
// Fixed-priority cell selector: the lowest-index pressed button wins.
module cell_priority_pick
  import tictactoe_pkg::*;
(
  input  logic [NUM_CELLS-1:0] req,
  output logic [NUM_CELLS-1:0] pick,
  output logic                 any_req
);

  // Isolate the lowest set bit with the two's-complement trick.
  assign pick    = req & (~req + {{(NUM_CELLS-1){1'b0}}, 1'b1});
  assign any_req = |req;

endmodule

// File: rtl/turn_scheduler.sv
// Move sequencer between the cell buttons and the board datapath: accepts one move,
// strobes the board, waits for the win detectors and keeps turn/result bookkeeping.
module turn_scheduler
  import tictactoe_pkg::*;
#(
  parameter int   SETTLE_CYCLES = 2,
  parameter logic FIRST_PLAYER  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] btn,
  input  logic       new_game,
  input  logic [8:0] cell_occ,
  input  logic       p1_win,
  input  logic       p2_win,
  output logic       write_en,
  output logic [8:0] write_sel,
  output logic       write_player,
  output logic       clear_board,
  output logic       turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       draw,
  output logic [3:0] move_count,
  output logic       illegal
);

  localparam logic [2:0] SETTLE_LOAD = (SETTLE_CYCLES < 1) ? 3'd1 :
                                       (SETTLE_CYCLES > 7) ? 3'd7 : 3'(SETTLE_CYCLES);
  localparam logic [3:0] MAX_MOVES   = 4'd9;

  sched_state_e state_r;
  logic [2:0]   settle_cnt_r;
  logic         write_en_r;
  logic [8:0]   write_sel_r;
  logic         write_player_r;
  logic         clear_board_r;
  logic         turn_r;
  logic         game_over_r;
  logic [1:0]   winner_r;
  logic         draw_r;
  logic [3:0]   move_count_r;
  logic         illegal_r;

  logic [8:0]   pick_s;
  logic         any_s;
  logic         occ_hit_s;
  logic         mover_win_s;
  logic         other_win_s;

  cell_priority_pick u_pick (
    .req     (btn),
    .pick    (pick_s),
    .any_req (any_s)
  );

  assign occ_hit_s   = |(pick_s & cell_occ);
  assign mover_win_s = (turn_r == P2) ? p2_win : p1_win;
  assign other_win_s = (turn_r == P2) ? p1_win : p2_win;

  // A new_game landing in the commit cycle cancels the board write immediately.
  assign write_en     = write_en_r & ~new_game;
  assign write_sel    = write_sel_r & {9{~new_game}};
  assign write_player = write_player_r;
  assign clear_board  = clear_board_r;
  assign turn         = turn_r;
  assign game_over    = game_over_r;
  assign winner       = winner_r;
  assign draw         = draw_r;
  assign move_count   = move_count_r;
  assign illegal      = illegal_r;

  // Scheduler FSM with all strobes and status registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_RELEASE;
      settle_cnt_r   <= 3'd0;
      write_en_r     <= 1'b0;
      write_sel_r    <= 9'd0;
      write_player_r <= 1'b0;
      clear_board_r  <= 1'b0;
      turn_r         <= FIRST_PLAYER;
      game_over_r    <= 1'b0;
      winner_r       <= WIN_NONE;
      draw_r         <= 1'b0;
      move_count_r   <= 4'd0;
      illegal_r      <= 1'b0;
    end else if (new_game) begin
      state_r        <= ST_RELEASE;
      settle_cnt_r   <= 3'd0;
      write_en_r     <= 1'b0;
      write_sel_r    <= 9'd0;
      write_player_r <= 1'b0;
      clear_board_r  <= 1'b1;
      turn_r         <= FIRST_PLAYER;
      game_over_r    <= 1'b0;
      winner_r       <= WIN_NONE;
      draw_r         <= 1'b0;
      move_count_r   <= 4'd0;
      illegal_r      <= 1'b0;
    end else begin
      write_en_r     <= 1'b0;
      write_sel_r    <= 9'd0;
      write_player_r <= 1'b0;
      clear_board_r  <= 1'b0;
      illegal_r      <= 1'b0;
      case (state_r)
        ST_RELEASE: begin
          if (btn == 9'd0) begin
            state_r <= ST_READY;
          end else begin
            state_r <= ST_RELEASE;
          end
        end
        ST_READY: begin
          if (!any_s) begin
            state_r <= ST_READY;
          end else if (occ_hit_s) begin
            illegal_r <= 1'b1;
            state_r   <= ST_RELEASE;
          end else begin
            // Strobe and count become visible together in the commit cycle.
            write_en_r     <= 1'b1;
            write_sel_r    <= pick_s;
            write_player_r <= turn_r;
            if (move_count_r < MAX_MOVES) begin
              move_count_r <= move_count_r + 4'd1;
            end else begin
              move_count_r <= move_count_r;
            end
            state_r <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          settle_cnt_r <= SETTLE_LOAD;
          state_r      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt_r <= 3'd1) begin
            state_r <= ST_EVAL;
          end else begin
            settle_cnt_r <= settle_cnt_r - 3'd1;
          end
        end
        ST_EVAL: begin
          // Mover's own line takes precedence over a flag for the other player.
          if (mover_win_s) begin
            winner_r    <= winner_code(turn_r);
            game_over_r <= 1'b1;
            state_r     <= ST_OVER;
          end else if (other_win_s) begin
            winner_r    <= winner_code(~turn_r);
            game_over_r <= 1'b1;
            state_r     <= ST_OVER;
          end else if (move_count_r == MAX_MOVES) begin
            draw_r      <= 1'b1;
            game_over_r <= 1'b1;
            state_r     <= ST_OVER;
          end else begin
            turn_r  <= ~turn_r;
            state_r <= ST_RELEASE;
          end
        end
        ST_OVER: begin
          state_r <= ST_OVER;
        end
        default: begin
          state_r <= ST_RELEASE;
        end
      endcase
    end
  end

endmodule
